// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per clock, with divide-by-zero and overflow resolved at acceptance.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             r_state, w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic               r_neg, r_rem_neg, r_busy, r_done;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand, r_quot, r_divisor, r_rem, r_result;

    logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic               w_div_zero, w_ovf, w_special;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_special_res;
    logic [WIDTH:0]     w_mul_sum, w_trial;
    logic [2*WIDTH-1:0] w_prod_step, w_prod_signed;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_step, w_quot_step, w_quot_signed, w_rem_signed, w_final;

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg    = w_a_signed & a[WIDTH-1];
    assign w_b_neg    = w_b_signed & b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -a : a;
    assign w_b_mag    = w_b_neg ? -b : b;

    assign w_div_zero = funct3[2] && (b == '0);
    assign w_ovf      = funct3[2] && !funct3[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = funct3[1] ? a : '1;
        else
            w_special_res = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // One shift-add multiply step and one restoring-divide step
    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_step = {w_mul_sum, r_prod[WIDTH-1:1]};
    assign w_trial     = {r_rem, r_quot[WIDTH-1]};
    assign w_fits      = (w_trial >= {1'b0, r_divisor});
    assign w_rem_step  = w_fits ? (w_trial[WIDTH-1:0] - r_divisor) : w_trial[WIDTH-1:0];
    assign w_quot_step = {r_quot[WIDTH-2:0], w_fits};

    assign w_prod_signed = r_neg ? -w_prod_step : w_prod_step;
    assign w_quot_signed = r_neg ? -w_quot_step : w_quot_step;
    assign w_rem_signed  = r_rem_neg ? -w_rem_step : w_rem_step;

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod_signed[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_signed[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_final = w_quot_signed;
            default:                w_final = w_rem_signed;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_special ? S_FIN : S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_result  <= '0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_FIN);
            case (r_state)
                S_IDLE: if (start) begin
                    r_op      <= funct3;
                    r_neg     <= w_a_neg ^ w_b_neg;
                    r_rem_neg <= w_a_neg;
                    r_cnt     <= '0;
                    r_prod    <= {{WIDTH{1'b0}}, w_b_mag};
                    r_mcand   <= w_a_mag;
                    r_quot    <= w_a_mag;
                    r_divisor <= w_b_mag;
                    r_rem     <= '0;
                    if (w_special) r_result <= w_special_res;
                end
                S_RUN: begin
                    r_cnt  <= r_cnt + CW'(1);
                    r_prod <= w_prod_step;
                    r_quot <= w_quot_step;
                    r_rem  <= w_rem_step;
                    if (r_cnt == LAST) r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results from an
// arithmetic reference model; a negedge monitor pops and compares on each done.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   funct3;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    typedef struct {
        logic [W-1:0] res;
        int           acc;
        int           lat;
        int           id;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0, failures = 0, cyc = 0, done_cnt = 0, next_id = 0;
    bit   prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: RISC-V M semantics via 64-bit / native SV arithmetic
    function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        longint       sx, sy;
        logic [63:0]  p;
        logic         ovf;
        sx  = $signed(x);
        sy  = $signed(y);
        ovf = (x == MINV) && (y == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: if (y == 0) return '1; else if (ovf) return MINV; else return $signed(x) / $signed(y);
            3'd5: if (y == 0) return '1; else return x / y;
            3'd6: if (y == 0) return x; else if (ovf) return '0; else return $signed(x) % $signed(y);
            default: if (y == 0) return x; else return x % y;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == MINV && y == 32'hFFFF_FFFF))) return 0;
        return W;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_done) begin
                check("busy_fall_after_done", {31'b0, busy}, 32'd0);
                check("done_single_cycle", {31'b0, done}, 32'd0);
            end
            if (done) begin
                done_cnt++;
                check("busy_during_done", {31'b0, busy}, 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=%h required=no_done", result);
                end else begin
                    m_e = sb.pop_front();
                    $display("txn id=%0d result=%h expected=%h latency=%0d", m_e.id, result, m_e.res, cyc - m_e.acc);
                    check("result", result, m_e.res);
                    check("latency", cyc - m_e.acc, m_e.lat);
                end
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        wait_idle();
        @(negedge clk);
        funct3 = f; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e.res = ref_model(f, x, y);
        e.acc = cyc;
        e.lat = ref_latency(f, x, y);
        e.id  = next_id++;
        sb.push_back(e);
        check("busy_rise", {31'b0, busy}, 32'd1);
        funct3 = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c0, d0, n;
        logic [2:0]   f;
        logic [W-1:0] x, y;

        reset = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        issue(3'd1, MINV, MINV);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd4, 32'd5, 32'd0);
        issue(3'd6, 32'd5, 32'd0);
        issue(3'd4, MINV, 32'hFFFF_FFFF);
        issue(3'd6, MINV, 32'hFFFF_FFFF);

        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = MINV; y = '1; end
                2: y = W'($urandom_range(1, 15));
                default: ;
            endcase
            issue(f, x, y);
        end

        // start held high: back-to-back acceptances every 34 cycles
        wait_idle();
        @(negedge clk);
        d0 = done_cnt;
        funct3 = 3'd3; a = $urandom; b = $urandom; start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            e.res = ref_model(3'd3, a, b);
            e.acc = c0 + 34 * k;
            e.lat = W;
            e.id  = next_id++;
            sb.push_back(e);
        end
        repeat (68) @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        check("held_start_done_count", done_cnt - d0, 32'd3);

        // a second start mid-RUN must be ignored
        issue(3'd5, 32'hDEAD_BEEF, 32'd13);
        repeat (10) @(posedge clk);
        #1 funct3 = 3'd0; a = $urandom; b = $urandom; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // asynchronous reset mid-DIVU aborts with no done
        issue(3'd5, 32'hFFFF_0000, 32'd3);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        check("async_reset_done", {31'b0, done}, 32'd0);
        check("async_reset_result", result, 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        issue(3'd5, 32'd9, 32'd3);

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit. Sits beside the ALU in the execute stage.
- Its result feeds the 2:1 result-select mux ahead of register writeback; the ALU result is the other mux input.
- Control logic holds the PC and blocks writeback while busy is high, then writes result when done pulses.
- Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU per the RISC-V M extension.

Parameters:
- WIDTH, 32, operand/result width in bits; even, >= 8.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only on a rising edge where busy=0.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  WIDTH  rs1 operand (dividend / multiplicand).
- b  input  WIDTH  rs2 operand (divisor / multiplier).
- busy  output  1  high while an operation is in flight (state != IDLE).
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  WIDTH  operation result; holds its last value until the next completion.

Behaviour:
- Reset is asynchronous and active-high. On assertion: state=IDLE, busy=0, done=0, result=0, iteration counter=0, internal operand/accumulator registers=0. This applies at any time, including mid-operation; the aborted op produces no done.
- States: IDLE, RUN, FIN.
- IDLE:
  - On an edge with start=1, latch funct3, a, b and signs, then enter RUN with counter=0.
  - a, b and funct3 may change freely after acceptance.
- Special cases go IDLE -> FIN directly (latency 1), with result set on the acceptance edge:
  - Divide by zero (b=0): DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
  - Multiplies have no special case.
- Operand preparation for the normal path:
  - Signed operands are converted to magnitudes.
  - Signedness: MULH signs a and b; MULHSU signs a only; MULHU and MUL treat both as unsigned magnitudes (MUL low word is sign-agnostic).
- RUN, multiply: one shift-add iteration per edge on a 2*WIDTH product register.
- RUN, divide: one restoring-division step per edge, producing quotient and remainder.
- RUN exit:
  - After exactly WIDTH iterations (counter WIDTH-1 on the final RUN edge), enter FIN.
  - On that edge apply sign correction and select the output:
    - Product negated if operand signs differ; MUL takes the low word, MULH* the high word.
    - Quotient negated if dividend and divisor signs differ.
    - Remainder takes the dividend's sign.
  - result is registered on that same edge.
- FIN: done=1, busy=1 for exactly one cycle, then unconditional return to IDLE.
- Timing: start accepted at edge E0 → normal ops see done high after edge E32 and low after E33; special cases see done high after E0.
- start while busy=1 (RUN or FIN) is ignored, with no queueing. start in the cycle after done (state IDLE) is accepted normally.
- done and busy are registered outputs with no combinational path from inputs.
- All arithmetic is modulo 2^WIDTH; internal accumulators are 2*WIDTH bits (mul) and WIDTH+1 bits (div partial remainder).

Test Plan:
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB. Checks: busy rises after the start edge; done pulses exactly one cycle, after the 32nd following edge; busy falls one cycle after done.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002. Operands are changed to garbage one cycle after start; results must be unaffected.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 0x00000005; done high the cycle after start. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0x00000000; same 1-cycle latency.
- Start held high continuously for 3 ops → exactly 3 done pulses, each 34 cycles apart. A second start pulse mid-RUN is ignored, giving no extra done and no change to the first result.
- Reset asserted asynchronously (between edges) at iteration 10 of a DIVU → busy=0, done=0, result=0 immediately, with no done afterwards. After release, DIVU 9/3 → 0x00000003 with normal latency.
